// File: rtl/aes_pkg.sv
// Purpose : shared constants and FSM state type for the AES output byte streamer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;
    localparam int BYTE_IDX_W  = 4;

    // IDLE: nothing presented on the byte port; SEND: byte_out carries a valid byte.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// Purpose : DEPTH x 128-bit synchronous FIFO holding whole ciphertext blocks.
// Latency : a write is visible at the head on the cycle after its edge; head read is combinational.
// Backpressure: none internal; the caller must gate wr_en with full and rd_en with empty.
//
// Ports: clk, rst (async, active-high), wr_en/wr_data push a block, rd_en pops the head,
//        rd_data is the current head, full/empty/count reflect the registered occupancy.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [AES_BLOCK_W-1:0]     wr_data,
    input  logic                       rd_en,
    output logic [AES_BLOCK_W-1:0]     rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [AES_BLOCK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Storage carries no reset: occupancy is tracked by count, so stale
    // contents are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/aes_byte_streamer.sv
// Purpose : captures AES ciphertext blocks on blk_valid and streams them out MSB byte first.
// Latency : block accepted at edge N -> byte 0 valid after edge N+1; 16 beats per block.
// Backpressure: byte_ready stalls the byte port; blk_valid while full (and no pop) drops the block and counts it.
//
// Ports: clk, rst (async, active-high); blk_in/blk_valid from the AES core;
//        byte_out/byte_valid/byte_ready/byte_last consumer handshake;
//        full/empty storage status; overflow/ovf_cnt drop reporting, cleared by clr_ovf.
module aes_byte_streamer
    import aes_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int OVF_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AES_BLOCK_W-1:0] blk_in,
    input  logic                   blk_valid,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_last,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [OVF_CNT_W-1:0]   ovf_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    stream_state_t          state;
    logic [BYTE_IDX_W-1:0]  byte_idx;
    logic [AES_BLOCK_W-1:0] head;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_after;
    logic                   beat;
    logic                   pop;
    logic                   accept;
    logic                   drop;
    logic [6:0]             byte_lsb;

    assign beat   = byte_valid & byte_ready;
    assign pop    = beat & byte_last;
    // A pop frees the head slot on the same edge, so a full FIFO can still
    // take a block that lands on the head's last beat.
    assign accept = blk_valid & (~full | pop);
    assign drop   = blk_valid & full & ~pop;

    // Occupancy as it will be after this edge; decides whether streaming continues.
    assign count_after = count + CNT_W'(accept) - CNT_W'(pop);

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (blk_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Byte k sits at bits [127-8k -: 8]; for a 4-bit index 8*(15-k) is just ~k shifted by 3.
    assign byte_lsb   = {~byte_idx, 3'b000};
    assign byte_valid = (state == SEND);
    assign byte_last  = byte_valid & (byte_idx == BYTE_IDX_W'(AES_BYTES - 1));
    assign byte_out   = byte_valid ? head[byte_lsb +: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    byte_idx <= '0;
                    if (count != '0) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (byte_last) begin
                            byte_idx <= '0;
                            if (count_after == '0) begin
                                state <= IDLE;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    byte_idx <= '0;
                end
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf wins: the flag stays set and the
    // count restarts at one so the fresh drop is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                ovf_cnt <= OVF_CNT_W'(1);
            end else if (~&ovf_cnt) begin
                ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_aes_byte_streamer.sv
// Purpose : self-checking bench for aes_byte_streamer against a queue-based reference model.
// Latency : model predicts byte_valid one edge after the stored-block queue becomes non-empty.
// Backpressure: byte_ready driven by the bench (fixed patterns and random).
module tb_aes_byte_streamer;

    localparam int DEPTH = 2;
    localparam int OVF_W = 8;
    localparam int OVF_MAX = (1 << OVF_W) - 1;
    localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [127:0]     blk_in = '0;
    logic             blk_valid = 1'b0;
    logic             byte_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_last;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [OVF_W-1:0] ovf_cnt;

    aes_byte_streamer #(
        .DEPTH     (DEPTH),
        .OVF_CNT_W (OVF_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: stored blocks in arrival order, position within the
    // head block, whether the byte port is presenting, and drop bookkeeping.
    logic [127:0] m_q[$];
    int           m_pos   = 0;
    bit           m_valid = 1'b0;
    bit           m_ovf   = 1'b0;
    int           m_cnt   = 0;

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic step(input bit bv, input logic [127:0] blk, input bit rdy, input bit clr);
        logic [127:0] sh;
        logic [7:0]   eb;
        bit           eb_last;
        bit           pop;
        bit           acc;
        bit           drp;
        bit           was_nonempty;
        blk_valid  = bv;
        blk_in     = blk;
        byte_ready = rdy;
        clr_ovf    = clr;
        @(negedge clk);
        eb = 8'h00;
        if (m_valid) begin
            sh = m_q[0] >> (8 * (15 - m_pos));
            eb = sh[7:0];
        end
        eb_last = m_valid && (m_pos == 15);

        n_checks++;
        if (byte_valid !== m_valid) $display("FAIL byte_valid t=%0t: got %b expected %b", $time, byte_valid, m_valid);
        else n_pass++;
        n_checks++;
        if (byte_out !== eb) $display("FAIL byte_out t=%0t pos=%0d: got %h expected %h", $time, m_pos, byte_out, eb);
        else n_pass++;
        n_checks++;
        if (byte_last !== eb_last) $display("FAIL byte_last t=%0t: got %b expected %b", $time, byte_last, eb_last);
        else n_pass++;
        n_checks++;
        if (full !== (m_q.size() == DEPTH)) $display("FAIL full t=%0t: got %b expected %b", $time, full, m_q.size() == DEPTH);
        else n_pass++;
        n_checks++;
        if (empty !== (m_q.size() == 0)) $display("FAIL empty t=%0t: got %b expected %b", $time, empty, m_q.size() == 0);
        else n_pass++;
        n_checks++;
        if (overflow !== m_ovf) $display("FAIL overflow t=%0t: got %b expected %b", $time, overflow, m_ovf);
        else n_pass++;
        n_checks++;
        if (ovf_cnt !== OVF_W'(m_cnt)) $display("FAIL ovf_cnt t=%0t: got %0d expected %0d", $time, ovf_cnt, m_cnt);
        else n_pass++;

        was_nonempty = (m_q.size() != 0);
        pop = m_valid && rdy && (m_pos == 15);
        acc = bv && ((m_q.size() < DEPTH) || pop);
        drp = bv && !acc;
        if (m_valid && rdy) m_pos = pop ? 0 : m_pos + 1;
        if (pop) m_q.delete(0);
        if (acc) m_q.push_back(blk);
        if (drp) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt + 1 > OVF_MAX) ? OVF_MAX : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (!m_valid) m_valid = was_nonempty;
        else if (pop) m_valid = (m_q.size() != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        blk_valid  = 1'b0;
        byte_ready = 1'b0;
        clr_ovf    = 1'b0;
        #1;
        n_checks++;
        if (byte_out !== 8'h00) $display("FAIL rst_byte_out: got %h expected 00", byte_out);
        else n_pass++;
        n_checks++;
        if (byte_valid !== 1'b0) $display("FAIL rst_byte_valid: got %b expected 0", byte_valid);
        else n_pass++;
        n_checks++;
        if (byte_last !== 1'b0) $display("FAIL rst_byte_last: got %b expected 0", byte_last);
        else n_pass++;
        n_checks++;
        if (full !== 1'b0) $display("FAIL rst_full: got %b expected 0", full);
        else n_pass++;
        n_checks++;
        if (empty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", empty);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", overflow);
        else n_pass++;
        n_checks++;
        if (ovf_cnt !== '0) $display("FAIL rst_ovf_cnt: got %0d expected 0", ovf_cnt);
        else n_pass++;
        m_q.delete();
        m_pos   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_single_block();
        step(1'b1, KAT, 1'b1, 1'b0);
        repeat (20) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        step(1'b1, KAT, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) begin
            step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        end
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        repeat (3) step(1'b1, rand_blk(), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        repeat (40) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_accept_on_pop();
        bit done;
        bit bv;
        done = 1'b0;
        step(1'b1, rand_blk(), 1'b0, 1'b0);
        step(1'b1, rand_blk(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            bv = !done && m_valid && (m_pos == 15) && (m_q.size() == DEPTH);
            step(bv, bv ? rand_blk() : 128'h0, 1'b1, 1'b0);
            if (bv) done = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, rand_blk(), 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (m_valid && (m_pos == 7)) break;
            step(1'b0, '0, 1'b1, 1'b0);
        end
        do_reset();
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, KAT, 1'b1, 1'b0);
        repeat (20) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_clr_ovf();
        step(1'b1, rand_blk(), 1'b0, 1'b0);
        step(1'b1, rand_blk(), 1'b0, 1'b0);
        repeat (5) step(1'b1, rand_blk(), 1'b0, 1'b0);
        step(1'b1, rand_blk(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        repeat (300) step(1'b1, rand_blk(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        repeat (40) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit bv;
        for (int i = 0; i < 1500; i++) begin
            bv = ($urandom_range(0, 9) == 0);
            step(bv, bv ? rand_blk() : 128'h0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (40) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_stall();
        test_overflow();
        test_accept_on_pop();
        test_reset_mid();
        test_clr_ovf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
